// File: rtl/uw_sync_ctrl.sv
// uw_sync_ctrl: unique-word frame sync controller (SEARCH -> VERIFY -> LOCK).
// Optional macro UW_SYNC_ROT_TRACK_EN: accept rotation slips on LOCK check hits.
module uw_sync_ctrl #(
    parameter int FRAME_LEN  = 256,
    parameter int DET_THRESH = 28,
    parameter int LOCK_HITS  = 2,
    parameter int MISS_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_en,
    input  logic       sym_valid,
    output logic       score_en,
    input  logic [4:0] score,
    input  logic [1:0] best_rot,
    output logic [1:0] state,
    output logic       locked,
    output logic [1:0] rot_out,
    output logic       uw_strobe,
    output logic       frame_strobe,
    output logic [2:0] miss_cnt
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
    localparam logic [4:0]    THR      = 5'(DET_THRESH);
    localparam logic [3:0]    HITS     = 4'(LOCK_HITS);
    localparam logic [2:0]    MISSL    = 3'(MISS_LIMIT);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_score_vld;
    logic [PW-1:0] r_pos;
    logic [PW-1:0] w_pos_nxt;
    logic [3:0]    r_hit_cnt;
    logic [3:0]    w_hit_nxt;
    logic [2:0]    r_miss_cnt;
    logic [2:0]    w_miss_nxt;
    logic [2:0]    w_miss_inc;
    logic [1:0]    r_rot;
    logic [1:0]    w_rot_nxt;
    logic          r_uw;
    logic          w_uw_nxt;
    logic          r_fs;
    logic          w_fs_nxt;
    logic          w_hit;
    logic          w_rot_ok;
    logic          w_check;

    assign score_en     = sym_valid & sync_en;
    assign state        = r_state;
    assign locked       = (r_state == S_LOCK);
    assign rot_out      = r_rot;
    assign uw_strobe    = r_uw;
    assign frame_strobe = r_fs;
    assign miss_cnt     = r_miss_cnt;

    assign w_hit      = (score >= THR);
    assign w_rot_ok   = (best_rot == r_rot);
    assign w_check    = r_score_vld && (r_pos == POS_LAST);
    assign w_miss_inc = r_miss_cnt + 3'd1;

    // State, counters and strobes register; reset clears all of it at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_score_vld <= 1'b0;
            r_pos       <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_rot       <= '0;
            r_uw        <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_vld <= score_en;
            r_pos       <= w_pos_nxt;
            r_hit_cnt   <= w_hit_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_rot       <= w_rot_nxt;
            r_uw        <= w_uw_nxt;
            r_fs        <= w_fs_nxt;
        end
    end

    // Next-state decode; a low enable wins over any score decision
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_rot_nxt   = r_rot;
        w_uw_nxt    = 1'b0;
        w_fs_nxt    = 1'b0;
        if (!sync_en) begin
            w_state_nxt = S_SEARCH;
            w_pos_nxt   = '0;
            w_hit_nxt   = '0;
            w_miss_nxt  = '0;
        end else if (r_score_vld) begin
            unique case (r_state)
                S_SEARCH: begin
                    w_pos_nxt = '0;
                    if (w_hit) begin
                        w_rot_nxt   = best_rot;
                        w_hit_nxt   = 4'd1;
                        w_miss_nxt  = '0;
                        w_state_nxt = (LOCK_HITS == 1) ? S_LOCK : S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (w_check) begin
                        w_pos_nxt = '0;
                        if (w_hit && w_rot_ok) begin
                            w_uw_nxt  = 1'b1;
                            w_hit_nxt = r_hit_cnt + 4'd1;
                            // anchor plus LOCK_HITS verified hits
                            if (r_hit_cnt >= HITS) begin
                                w_state_nxt = S_LOCK;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_state_nxt = S_SEARCH;
                            w_hit_nxt   = '0;
                        end
                    end else begin
                        w_pos_nxt = r_pos + PW'(1);
                    end
                end
                S_LOCK: begin
                    if (w_check) begin
                        w_pos_nxt = '0;
                        w_fs_nxt  = 1'b1;
                        if (w_hit && w_rot_ok) begin
                            w_miss_nxt = '0;
                            w_uw_nxt   = 1'b1;
                        end
`ifdef UW_SYNC_ROT_TRACK_EN
                        else if (w_hit) begin
                            w_rot_nxt  = best_rot;
                            w_miss_nxt = '0;
                            w_uw_nxt   = 1'b1;
                        end
`endif
                        else if (w_miss_inc >= MISSL) begin
                            w_state_nxt = S_SEARCH;
                            w_miss_nxt  = '0;
                            w_hit_nxt   = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end else begin
                        w_pos_nxt = r_pos + PW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_SEARCH;
                    w_pos_nxt   = '0;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

endmodule
